// File: rtl/menu_pkg.sv
// Shared types and helpers for the parametrised menu selector.
package menu_pkg;

  typedef enum logic [0:0] {
    StMenu     = 1'b0,
    StSelected = 1'b1
  } state_e;

  localparam int unsigned TIMEOUT_W = 20;

  // Widest legal menu is 16 options; callers truncate to their own width.
  function automatic logic [15:0] idx_to_onehot(input logic [3:0] idx);
    return 16'(1) << idx;
  endfunction

endpackage

// File: rtl/menu_select_n_if.sv
// Front-panel button / selection bus between the panel and the menu selector.
interface menu_select_n_if #(
  parameter int unsigned N_OPTS = 4
);
  localparam int unsigned IDX_W = $clog2(N_OPTS);

  logic              AD;
  logic              AT;
  logic              SEL;
  logic              CLC;
  logic [IDX_W-1:0]  cursor;
  logic [N_OPTS-1:0] op;
  logic              sel_active;
  logic              sel_strobe;

  modport master (
    output AD, AT, SEL, CLC,
    input  cursor, op, sel_active, sel_strobe
  );

  modport slave (
    input  AD, AT, SEL, CLC,
    output cursor, op, sel_active, sel_strobe
  );

endinterface

// File: rtl/btn_edge_det.sv
// Rising-edge detector for a bank of level buttons; history resets high so a
// button held through reset release produces no event.
module btn_edge_det #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] btn,
  output logic [W-1:0] rise
);

  logic [W-1:0] hist_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '1;
    end else begin
      hist_q <= btn;
    end
  end

  assign rise = btn & ~hist_q;

endmodule

// File: rtl/menu_select_n.sv
// N-option menu selector with edge-qualified buttons, one-hot selection and an
// optional inactivity timeout. Define MENU_WRAP_EN to make the cursor wrap.
module menu_select_n
  import menu_pkg::*;
#(
  parameter int unsigned N_OPTS      = 4,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input logic            clk,
  input logic            reset,
  menu_select_n_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(N_OPTS);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_OPTS - 1);
  localparam bit TimeoutEn = (TIMEOUT_CYC != 0);
  localparam logic [TIMEOUT_W-1:0] TermCnt = TimeoutEn ? TIMEOUT_W'(TIMEOUT_CYC - 1) : '0;

  logic [3:0] btn;
  logic [3:0] ev;
  logic       ev_ad, ev_at, ev_sel, ev_clc;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      cursor_q, cursor_d;
  logic [N_OPTS-1:0]     op_q, op_d;
  logic                  active_q, active_d;
  logic                  strobe_q, strobe_d;
  logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;

  assign btn = {bus.AD, bus.AT, bus.SEL, bus.CLC};

  btn_edge_det #(
    .W(4)
  ) u_edge (
    .clk  (clk),
    .reset(reset),
    .btn  (btn),
    .rise (ev)
  );

  assign ev_ad  = ev[3];
  assign ev_at  = ev[2];
  assign ev_sel = ev[1];
  assign ev_clc = ev[0];

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    op_d     = op_q;
    active_d = active_q;
    strobe_d = 1'b0;
    cnt_d    = cnt_q;

    case (state_q)
      StMenu: begin
        op_d     = '0;
        active_d = 1'b0;
        cnt_d    = '0;
        if (cursor_q > LastIdx) begin
          cursor_d = '0;
        end else if (ev_ad) begin
          if (cursor_q == LastIdx) begin
`ifdef MENU_WRAP_EN
            cursor_d = '0;
`else
            cursor_d = cursor_q;
`endif
          end else begin
            cursor_d = cursor_q + 1'b1;
          end
        end else if (ev_at) begin
          if (cursor_q == '0) begin
`ifdef MENU_WRAP_EN
            cursor_d = LastIdx;
`else
            cursor_d = cursor_q;
`endif
          end else begin
            cursor_d = cursor_q - 1'b1;
          end
        end else if (ev_sel) begin
          state_d  = StSelected;
          op_d     = N_OPTS'(idx_to_onehot(4'(cursor_q)));
          active_d = 1'b1;
          strobe_d = 1'b1;
        end
      end

      StSelected: begin
        // Cancel and timeout collapse into one exit when they coincide.
        if (ev_clc || (TimeoutEn && (cnt_q == TermCnt))) begin
          state_d  = StMenu;
          cursor_d = '0;
          op_d     = '0;
          active_d = 1'b0;
          cnt_d    = '0;
        end else if (TimeoutEn) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d  = StMenu;
        cursor_d = '0;
        op_d     = '0;
        active_d = 1'b0;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StMenu;
      cursor_q <= '0;
      op_q     <= '0;
      active_q <= 1'b0;
      strobe_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      op_q     <= op_d;
      active_q <= active_d;
      strobe_q <= strobe_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.cursor     = cursor_q;
  assign bus.op         = op_q;
  assign bus.sel_active = active_q;
  assign bus.sel_strobe = strobe_q;

endmodule

// File: tb/tb_menu_select_n.sv
// Scoreboard bench: dut0 (5 options, no timeout) and dut1 (5 options, timeout 8).
module tb_menu_select_n;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  menu_select_n_if #(.N_OPTS(5)) bus0 ();
  menu_select_n_if #(.N_OPTS(5)) bus1 ();

  menu_select_n #(.N_OPTS(5), .TIMEOUT_CYC(0)) dut0 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus0)
  );

  menu_select_n #(.N_OPTS(5), .TIMEOUT_CYC(8)) dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1)
  );

  typedef struct {
    logic [9:0] v;
    string      nm;
  } exp_t;

  exp_t  q0[$];
  exp_t  q1[$];
  int    n_checks = 0;
  int    n_errors = 0;
  string tname = "reset";

  // Packed view: {cursor[2:0], op[4:0], sel_active, sel_strobe}
  function automatic logic [9:0] pk(input int c, input logic [4:0] o, input logic a,
                                    input logic s);
    return {3'(c), o, a, s};
  endfunction

  function automatic logic [9:0] obs0();
    return {bus0.cursor, bus0.op, bus0.sel_active, bus0.sel_strobe};
  endfunction

  function automatic logic [9:0] obs1();
    return {bus1.cursor, bus1.op, bus1.sel_active, bus1.sel_strobe};
  endfunction

  task automatic chk(input string nm, input logic [9:0] got, input logic [9:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got cur=%0d op=%b act=%b stb=%b, want cur=%0d op=%b act=%b stb=%b",
               nm, got[9:7], got[6:2], got[1], got[0], want[9:7], want[6:2], want[1],
               want[0]);
    end
  endtask

  // Drive buttons {AD,AT,SEL,CLC} on one DUT and queue its outputs after the next edge.
  task automatic step(input int d, input logic [3:0] b, input int c, input logic [4:0] o,
                      input logic a, input logic s);
    exp_t e;
    @(negedge clk);
    if (d == 0) {bus0.AD, bus0.AT, bus0.SEL, bus0.CLC} = b;
    else        {bus1.AD, bus1.AT, bus1.SEL, bus1.CLC} = b;
    e.v  = pk(c, o, a, s);
    e.nm = tname;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk({"dut0 ", e.nm}, obs0(), e.v);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk({"dut1 ", e.nm}, obs1(), e.v);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    {bus0.AD, bus0.AT, bus0.SEL, bus0.CLC} = 4'b1000;
    {bus1.AD, bus1.AT, bus1.SEL, bus1.CLC} = 4'b0000;

    #12;
    chk("reset dut0", obs0(), pk(0, 5'b0, 1'b0, 1'b0));
    chk("reset dut1", obs1(), pk(0, 5'b0, 1'b0, 1'b0));

    // AD held through reset release must not move the cursor.
    @(negedge clk);
    reset = 1'b1;
    tname = "ad_held_thru_reset";
    step(0, 4'b1000, 0, 5'b0, 1'b0, 1'b0);
    step(0, 4'b1000, 0, 5'b0, 1'b0, 1'b0);
    step(0, 4'b0000, 0, 5'b0, 1'b0, 1'b0);

    tname = "ad_pulses";
    for (int i = 1; i <= 6; i++) begin
`ifdef MENU_WRAP_EN
      e = i % 5;
`else
      e = (i > 4) ? 4 : i;
`endif
      step(0, 4'b1000, e, 5'b0, 1'b0, 1'b0);
      step(0, 4'b0000, e, 5'b0, 1'b0, 1'b0);
    end

    tname = "at_pulses";
    for (int i = 1; i <= 7; i++) begin
`ifdef MENU_WRAP_EN
      e = (1 - i + 10) % 5;
`else
      e = (4 - i < 0) ? 0 : 4 - i;
`endif
      step(0, 4'b0100, e, 5'b0, 1'b0, 1'b0);
      step(0, 4'b0000, e, 5'b0, 1'b0, 1'b0);
    end

    // Bring the cursor to 2 from either end.
    tname = "to_cursor2";
`ifdef MENU_WRAP_EN
    step(0, 4'b0100, 3, 5'b0, 1'b0, 1'b0);
    step(0, 4'b0000, 3, 5'b0, 1'b0, 1'b0);
    step(0, 4'b0100, 2, 5'b0, 1'b0, 1'b0);
    step(0, 4'b0000, 2, 5'b0, 1'b0, 1'b0);
`else
    step(0, 4'b1000, 1, 5'b0, 1'b0, 1'b0);
    step(0, 4'b0000, 1, 5'b0, 1'b0, 1'b0);
    step(0, 4'b1000, 2, 5'b0, 1'b0, 1'b0);
    step(0, 4'b0000, 2, 5'b0, 1'b0, 1'b0);
`endif

    tname = "sel_held";
    step(0, 4'b0010, 2, 5'b00100, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) step(0, 4'b0010, 2, 5'b00100, 1'b1, 1'b0);
    step(0, 4'b0000, 2, 5'b00100, 1'b1, 1'b0);

    tname = "ad_in_selected";
    step(0, 4'b1000, 2, 5'b00100, 1'b1, 1'b0);
    step(0, 4'b0000, 2, 5'b00100, 1'b1, 1'b0);

    tname = "clc_exit";
    step(0, 4'b0001, 0, 5'b0, 1'b0, 1'b0);
    step(0, 4'b0000, 0, 5'b0, 1'b0, 1'b0);

    tname = "ad_beats_sel";
    step(0, 4'b1000, 1, 5'b0, 1'b0, 1'b0);
    step(0, 4'b0000, 1, 5'b0, 1'b0, 1'b0);
    step(0, 4'b1010, 2, 5'b0, 1'b0, 1'b0);
    step(0, 4'b0000, 2, 5'b0, 1'b0, 1'b0);
    step(0, 4'b0000, 2, 5'b0, 1'b0, 1'b0);

    tname = "timeout";
    step(1, 4'b0010, 0, 5'b00001, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step(1, 4'b0000, 0, 5'b00001, 1'b1, 1'b0);
    step(1, 4'b0000, 0, 5'b0, 1'b0, 1'b0);
    step(1, 4'b0000, 0, 5'b0, 1'b0, 1'b0);

    tname = "timeout_with_clc";
    step(1, 4'b0010, 0, 5'b00001, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1, 4'b0000, 0, 5'b00001, 1'b1, 1'b0);
    step(1, 4'b0001, 0, 5'b0, 1'b0, 1'b0);
    step(1, 4'b0000, 0, 5'b0, 1'b0, 1'b0);
    step(1, 4'b0000, 0, 5'b0, 1'b0, 1'b0);

    tname = "reselect";
    step(0, 4'b0010, 2, 5'b00100, 1'b1, 1'b1);
    step(0, 4'b0000, 2, 5'b00100, 1'b1, 1'b0);

    // Let the monitor drain, then assert reset between clock edges.
    @(posedge clk);
    #3;
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("async_reset dut0", obs0(), pk(0, 5'b0, 1'b0, 1'b0));
    chk("async_reset dut1", obs1(), pk(0, 5'b0, 1'b0, 1'b0));
    @(negedge clk);
    reset = 1'b1;
    tname = "after_reset";
    step(0, 4'b0000, 0, 5'b0, 1'b0, 1'b0);
    step(0, 4'b0000, 0, 5'b0, 1'b0, 1'b0);

    @(posedge clk);
    #4;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
